// File: rtl/battle_unit.sv
// battle_unit: one combat unit that spawns, advances, attacks on a cooldown, takes damage and holds a death state.
// Ports: clk/reset (sync, active-high); canSpawn, spawnType: spawn request;
//        moveSCEN, damageSCEN, damageIn: move tick and qualified damage; unitFront: opposing front position;
//        position, damageOut, unitType, health, dead: registered unit status.
// Optional: define BATTLE_UNIT_REGEN_EN to regain 1 health per undamaged move tick.
module battle_unit #(
    parameter int POS_W        = 9,
    parameter int DMG_W        = 8,
    parameter int DIR          = 0,
    parameter int SPAWN_POS    = 0,
    parameter int ATK_COOLDOWN = 4,
    parameter int DEAD_HOLD    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             canSpawn,
    input  logic [1:0]       spawnType,
    input  logic             moveSCEN,
    input  logic             damageSCEN,
    input  logic [DMG_W-1:0] damageIn,
    input  logic [POS_W-1:0] unitFront,
    output logic [POS_W-1:0] position,
    output logic [DMG_W-1:0] damageOut,
    output logic [1:0]       unitType,
    output logic [DMG_W-1:0] health,
    output logic             dead
);
    localparam int CW = $clog2(ATK_COOLDOWN + 1);
    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam logic [POS_W-1:0] SPAWN = POS_W'(SPAWN_POS);
    typedef enum logic [2:0] {IDLE = 3'd0, DEPLOY = 3'd1, ALIVE = 3'd2, DYING = 3'd3} state_t;
    function automatic logic [DMG_W-1:0] tab_hp(input logic [1:0] t);
        return t == 2'd1 ? {DMG_W{1'b1}} : t == 2'd2 ? DMG_W'(8'hC0) : DMG_W'(8'h80);
    endfunction
    function automatic logic [DMG_W-1:0] tab_pw(input logic [1:0] t);
        return t == 2'd1 ? DMG_W'(8'h20) : t == 2'd2 ? DMG_W'(8'h40) : DMG_W'(8'h80);
    endfunction
    state_t state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DMG_W-1:0] dmg_q, dmg_d, hp_q, hp_d, pw_q, pw_d;
    logic [1:0] type_q, type_d, spawn_q, spawn_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [HW-1:0] hold_q, hold_d;
    logic dead_q, dead_d;
    logic blocked;
    logic [POS_W-1:0] step;
    assign blocked = DIR == 0 ? pos_q >= unitFront : pos_q <= unitFront;
    // Saturating single step toward the opposing front.
    assign step = DIR == 0 ? (&pos_q ? pos_q : pos_q + 1'b1) : (~|pos_q ? pos_q : pos_q - 1'b1);
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dmg_d   = '0;
        type_d  = type_q;
        hp_d    = hp_q;
        pw_d    = pw_q;
        cool_d  = cool_q;
        hold_d  = hold_q;
        spawn_d = spawn_q;
        case (state_q)
            IDLE: begin
                pos_d = SPAWN;
                if (canSpawn && spawnType != 2'd0) begin
                    spawn_d = spawnType;
                    state_d = DEPLOY;
                end
            end
            DEPLOY: begin
                hp_d    = tab_hp(spawn_q);
                pw_d    = tab_pw(spawn_q);
                type_d  = spawn_q;
                state_d = ALIVE;
            end
            ALIVE: begin
                // A lethal hit wins over any move tick in the same cycle.
                if (damageSCEN && hp_q <= damageIn) begin
                    hp_d    = '0;
                    state_d = DYING;
                    hold_d  = HW'(DEAD_HOLD - 1);
                end else begin
                    if (damageSCEN)
                        hp_d = hp_q - damageIn;
`ifdef BATTLE_UNIT_REGEN_EN
                    else if (moveSCEN && hp_q < tab_hp(type_q))
                        hp_d = hp_q + 1'b1;
`endif
                    if (moveSCEN) begin
                        if (!blocked) begin
                            pos_d  = step;
                            cool_d = '0;
                        end else if (cool_q == '0) begin
                            dmg_d  = pw_q;
                            cool_d = CW'(ATK_COOLDOWN - 1);
                        end else begin
                            cool_d = cool_q - 1'b1;
                        end
                    end
                end
            end
            DYING: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                    type_d  = '0;
                    pos_d   = SPAWN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pos_d   = SPAWN;
            end
        endcase
        dead_d = state_d != ALIVE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= SPAWN;
            dmg_q   <= '0;
            type_q  <= '0;
            hp_q    <= '0;
            pw_q    <= '0;
            cool_q  <= '0;
            hold_q  <= '0;
            spawn_q <= '0;
            dead_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dmg_q   <= dmg_d;
            type_q  <= type_d;
            hp_q    <= hp_d;
            pw_q    <= pw_d;
            cool_q  <= cool_d;
            hold_q  <= hold_d;
            spawn_q <= spawn_d;
            dead_q  <= dead_d;
        end
    end
    assign position  = pos_q;
    assign damageOut = dmg_q;
    assign unitType  = type_q;
    assign health    = hp_q;
    assign dead      = dead_q;
endmodule

// File: doc/battle_unit.md
Name: battle_unit

Overview:
- Parametrised successor to the single-direction enemy unit FSM: one combat unit (enemy or player side) that spawns, advances one step per move tick, attacks with cooldown when blocked, takes damage and plays a timed death hold before it can respawn.
- Sits under the top-level battlefield controller. The controller supplies the move/damage strobes and the opposing front position, and consumes position, damage and type for collision and sprite logic.

Parameters:
- POS_W, 9, width of position and unitFront.
- DMG_W, 8, width of damageIn, damageOut, power and health.
- DIR, 0, 0 = advances toward increasing position (enemy side); 1 = toward decreasing position (player side).
- SPAWN_POS, 0, position loaded in IDLE (POS_W bits).
- ATK_COOLDOWN, 4, blocked move ticks per attack; minimum 1.
- DEAD_HOLD, 10, cycles spent in DYING; minimum 1.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- canSpawn, in, 1, spawn request; sampled only in IDLE.
- spawnType, in, 2, requested type; 0 = none.
- moveSCEN, in, 1, single-cycle move/attack tick.
- damageSCEN, in, 1, single-cycle strobe qualifying damageIn.
- damageIn, in, DMG_W, damage applied this cycle.
- unitFront, in, POS_W, position of the opposing frontmost unit.
- position, out, POS_W, current position.
- damageOut, out, DMG_W, attack strike, single-cycle pulse.
- unitType, out, 2, current type; 0 = empty slot.
- health, out, DMG_W, remaining health.
- dead, out, 1, 1 in every state except ALIVE.

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset takes effect at the next clk edge and overrides all other inputs, mid-operation included:
  - state=IDLE, position=SPAWN_POS, damageOut=0, unitType=0, health=0, dead=1, cooldown=0.
- Type table (health, power): type 1 = (all ones, 0x20); type 2 = (0xC0, 0x40); type 3 = (0x80, 0x80). Values are for DMG_W=8; for other widths, zero-extend or truncate from the MSB side.
- IDLE:
  - Holds position=SPAWN_POS and damageOut=0.
  - canSpawn=1 with spawnType!=0 latches the type and goes to DEPLOY.
  - spawnType=0 is ignored.
- DEPLOY (exactly 1 cycle):
  - Loads health and power from the table and sets unitType.
  - Moves to ALIVE; dead falls to 0 on that edge.
  - Strobes arriving during DEPLOY are ignored.
- ALIVE, damage (evaluated first):
  - If damageSCEN and health <= damageIn: health=0, damageOut=0, go to DYING. A moveSCEN in the same cycle is suppressed.
  - Else if damageSCEN: health -= damageIn.
  - damageIn without damageSCEN has no effect.
- ALIVE, move (on moveSCEN, unit not killed this cycle):
  - Blocked is defined as position >= unitFront when DIR=0, and position <= unitFront when DIR=1.
  - Not blocked: step one toward the front, damageOut=0, cooldown=0. Position saturates at 0 and at 2^POS_W-1 and never wraps.
  - Blocked with cooldown==0: damageOut=power for one cycle, then cooldown=ATK_COOLDOWN-1.
  - Blocked with cooldown!=0: cooldown decrements, damageOut=0.
- damageOut returns to 0 on the cycle after any strike.
- DYING:
  - dead=1, damageOut=0, position held.
  - unitType is retained for the death sprite.
  - After DEAD_HOLD cycles, go to IDLE; unitType=0 on that edge.
  - canSpawn is ignored while in DYING.
- Illegal or unreachable state encodings recover to IDLE on the next clk edge.
- Latency: spawn request to dead=0 is 2 cycles. Kill to dead=1 is 1 cycle.

Optional Feature:
- Macro: BATTLE_UNIT_REGEN_EN.
- Defined: in ALIVE, a moveSCEN cycle with no damageSCEN increments health by 1, saturating at the table health for the unit's type. Movement and attack proceed normally in the same cycle.
- Undefined: health only ever decreases, and the saturation logic is not synthesised.

Test Plan:
- Spawn and advance: reset, then canSpawn=1 with spawnType=1, DIR=0, unitFront=5, moveSCEN every 3rd cycle.
  - Required: dead=0 two cycles after the request; health=0xFF; position steps 0 to 5; damageOut stays 0.
- Attack with cooldown: blocked at position 5, ATK_COOLDOWN=4, 8 move ticks.
  - Required: damageOut=0x20 pulses on ticks 1 and 5 only, each one cycle wide.
- Damage and kill: type 3 unit, damageSCEN with damageIn=0x30 twice, then 0x20.
  - Required: health goes 0x80, 0x50, 0x20, then 0. DYING is entered with dead=1 and unitType still 3.
- Kill priority: damageSCEN (damageIn=0xFF) and moveSCEN in the same cycle while unblocked.
  - Required: position unchanged, DYING entered; after DEAD_HOLD=10 cycles IDLE is reached with unitType=0.
- Reverse direction and saturation: DIR=1, SPAWN_POS=0, unitFront=0.
  - Required: unit is blocked immediately, position stays 0, and it attacks.
- Reset mid-operation: reset asserted during ALIVE at position 3 with health 0x50.
  - Required: next edge gives IDLE, position=SPAWN_POS, health=0, dead=1, damageOut=0.
